sr_mem_responder: RTL

SR_MEM_RESPONDER -- requirements
Module: sr_mem_responder

---
 rtl/sr_mem_responder_pkg.sv | 21 ++
 rtl/sr_rd_pipe.sv | 50 +++++
 rtl/sr_mem_responder.sv | 96 +++++++++
 3 files changed

// File: rtl/sr_mem_responder_pkg.sv
`default_nettype none
// ============================================================================
// sr_mem_responder_pkg : shared widths, latency default and counter helper
// Rev 1.0
// ============================================================================
package sr_mem_responder_pkg;

  localparam int DATAWIDTH          = 8;
  localparam int ADDRWIDTH          = 4;
  localparam int MEM_RD_LAT_DEFAULT = 2;
  localparam int CNT_WIDTH          = 16;

  typedef logic [CNT_WIDTH-1:0] cnt_t;

  // Counters stick at all-ones instead of wrapping.
  function automatic cnt_t sat_inc(input cnt_t v);
    return (v == '1) ? v : v + cnt_t'(1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/sr_rd_pipe.sv
`default_nettype none
// ============================================================================
// sr_rd_pipe : fixed-latency shift pipeline carrying {valid, err, data}
// Rev 1.0
// ============================================================================
module sr_rd_pipe #(
  parameter int LAT = 2,
  parameter int DW  = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  input  logic          in_err,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  output logic          out_err,
  output logic [DW-1:0] out_data
);

  logic [LAT-1:0] r_valid;
  logic [LAT-1:0] r_err;
  logic [DW-1:0]  r_data [LAT];

  // Only the valid bits need clearing; stale err/data are ignored without valid.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_valid <= '0;
    end else begin
      r_valid[0] <= in_valid;
      for (int i = 1; i < LAT; i++) begin
        r_valid[i] <= r_valid[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    r_err[0]  <= in_err;
    r_data[0] <= in_data;
    for (int i = 1; i < LAT; i++) begin
      r_err[i]  <= r_err[i-1];
      r_data[i] <= r_data[i-1];
    end
  end

  assign out_valid = r_valid[LAT-1];
  assign out_err   = r_err[LAT-1];
  assign out_data  = r_data[LAT-1];

endmodule
`default_nettype wire

// File: rtl/sr_mem_responder.sv
`default_nettype none
// ============================================================================
// sr_mem_responder : 1W/1R register memory with pipelined, error-tagged reads
// Rev 1.0
// ============================================================================
module sr_mem_responder
  import sr_mem_responder_pkg::*;
#(
  parameter int DATAWIDTH  = sr_mem_responder_pkg::DATAWIDTH,
  parameter int ADDRWIDTH  = sr_mem_responder_pkg::ADDRWIDTH,
  parameter int MEM_RD_LAT = sr_mem_responder_pkg::MEM_RD_LAT_DEFAULT
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 mem_wr_en_in,
  input  logic                 mem_rd_en_in,
  input  logic [ADDRWIDTH-1:0] mem_addr_in,
  input  logic [ADDRWIDTH-1:0] mem_rd_addr_in,
  input  logic [DATAWIDTH-1:0] mem_data_in,
  output logic [DATAWIDTH-1:0] dataout,
  output logic                 DataValid,
  output logic                 RdErr,
  output logic [CNT_WIDTH-1:0] wr_count,
  output logic [CNT_WIDTH-1:0] rd_count
);

  localparam int DEPTH = 1 << ADDRWIDTH;

  logic [DATAWIDTH-1:0] r_mem [DEPTH];
  logic [DEPTH-1:0]     r_written;

  logic                 w_rd_err;
  logic [DATAWIDTH-1:0] w_rd_data;
  logic                 w_pipe_valid;
  logic                 w_pipe_err;
  logic [DATAWIDTH-1:0] w_pipe_data;

  // Sampling the arrays before the edge commits gives read-before-write.
  assign w_rd_err  = ~r_written[mem_rd_addr_in];
  assign w_rd_data = w_rd_err ? '0 : r_mem[mem_rd_addr_in];

  always_ff @(posedge clk) begin
    if (mem_wr_en_in) begin
      r_mem[mem_addr_in] <= mem_data_in;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_written <= '0;
    end else if (mem_wr_en_in) begin
      r_written[mem_addr_in] <= 1'b1;
    end
  end

  sr_rd_pipe #(
    .LAT (MEM_RD_LAT),
    .DW  (DATAWIDTH)
  ) u_rd_pipe (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (mem_rd_en_in),
    .in_err    (w_rd_err),
    .in_data   (w_rd_data),
    .out_valid (w_pipe_valid),
    .out_err   (w_pipe_err),
    .out_data  (w_pipe_data)
  );

  // Final output stage: dataout holds between pulses, RdErr only alongside DataValid.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dataout   <= '0;
      DataValid <= 1'b0;
      RdErr     <= 1'b0;
    end else begin
      DataValid <= w_pipe_valid;
      RdErr     <= w_pipe_valid & w_pipe_err;
      if (w_pipe_valid) begin
        dataout <= w_pipe_data;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_count <= '0;
      rd_count <= '0;
    end else begin
      if (mem_wr_en_in) wr_count <= sat_inc(wr_count);
      if (mem_rd_en_in) rd_count <= sat_inc(rd_count);
    end
  end

endmodule
`default_nettype wire
